registro_temp_prom: RTL and testbench

Parametrised temperature sample register with a circular history buffer. Each sample is latched from the temperature decoder output. The block produces a running average over the last 2^DEPTH_LOG2 samples, min/max tracking, and a hysteresis over-temperature alarm. It sits between the decoder (DecoT) and the display/control logic, and supersedes the single 8-bit sample register.

---
 rtl/registro_temp_prom.sv | 106 ++++++++++
 tb/tb_registro_temp_prom.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/registro_temp_prom.sv
// Temperature sample register with circular history buffer.
// Provides running average, min/max tracking and a hysteresis alarm.
module registro_temp_prom #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter int T_HIGH     = 40,
  parameter int T_LOW      = 35
) (
  input  logic             Clk_R,
  input  logic             Rst_R_n,
  input  logic             Enable_R,
  input  logic             Clr_R,
  input  logic [WIDTH-1:0] DecoT,
  output logic [WIDTH-1:0] Reg_Temp,
  output logic [WIDTH-1:0] Prom_Temp,
  output logic [WIDTH-1:0] Max_Temp,
  output logic [WIDTH-1:0] Min_Temp,
  output logic             Valid_R,
  output logic             Alarm_R
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW    = WIDTH + DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0]    FULL = CW'(DEPTH);
  localparam logic [WIDTH-1:0] TH   = WIDTH'(T_HIGH);
  localparam logic [WIDTH-1:0] TL   = WIDTH'(T_LOW);

  logic [WIDTH-1:0]      hist_q [DEPTH];
  logic [WIDTH-1:0]      hist_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic [WIDTH-1:0]      reg_q, reg_d;
  logic [WIDTH-1:0]      max_q, max_d;
  logic [WIDTH-1:0]      min_q, min_d;
  logic                  alarm_q, alarm_d;

  assign Valid_R   = (cnt_q == FULL);
  assign Prom_Temp = Valid_R ? sum_q[SW-1:DEPTH_LOG2] : '0;
  assign Reg_Temp  = reg_q;
  assign Max_Temp  = max_q;
  assign Min_Temp  = min_q;
  assign Alarm_R   = alarm_q;

  always_comb begin
    hist_d  = hist_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    reg_d   = reg_q;
    max_d   = max_q;
    min_d   = min_q;
    alarm_d = alarm_q;

    if (Clr_R) begin
      for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
      wp_d  = '0;
      cnt_d = '0;
      sum_d = '0;
      max_d = '0;
      min_d = '1;
    end else if (Enable_R) begin
      // Empty slots hold 0, so subtracting the overwritten entry is safe during fill
      hist_d[wp_q] = DecoT;
      wp_d  = wp_q + 1'b1;
      sum_d = sum_q + SW'(DecoT) - SW'(hist_q[wp_q]);
      reg_d = DecoT;
      max_d = (DecoT > max_q) ? DecoT : max_q;
      min_d = (DecoT < min_q) ? DecoT : min_q;
      cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + CW'(1);
    end

    if (Clr_R || !Valid_R) begin
      alarm_d = 1'b0;
    end else if (Prom_Temp >= TH) begin
      alarm_d = 1'b1;
    end else if (Prom_Temp <= TL) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_R) begin
    if (!Rst_R_n) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      wp_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      reg_q   <= '0;
      max_q   <= '0;
      min_q   <= '1;
      alarm_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= hist_d[i];
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      reg_q   <= reg_d;
      max_q   <= max_d;
      min_q   <= min_d;
      alarm_q <= alarm_d;
    end
  end

endmodule

// File: tb/tb_registro_temp_prom.sv
// Directed testbench for registro_temp_prom.
// Expected values are hand-computed from the average/min/max rules.
module tb_registro_temp_prom;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [7:0] deco;
  logic [7:0] reg_t, prom_t, max_t, min_t;
  logic       valid, alarm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  registro_temp_prom #(
    .WIDTH(8), .DEPTH_LOG2(2), .T_HIGH(40), .T_LOW(35)
  ) dut (
    .Clk_R(clk),
    .Rst_R_n(rst_n),
    .Enable_R(en),
    .Clr_R(clr),
    .DecoT(deco),
    .Reg_Temp(reg_t),
    .Prom_Temp(prom_t),
    .Max_Temp(max_t),
    .Min_Temp(min_t),
    .Valid_R(valid),
    .Alarm_R(alarm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] v);
    en   = 1'b1;
    deco = v;
    tick();
    en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; en = 1'b1; deco = 8'd77;
    tick(); tick();
    total++; if (reg_t !== 8'd0) begin bad++; $display("FAIL reset_reg got=%0d exp=0", reg_t); end
    total++; if (prom_t !== 8'd0) begin bad++; $display("FAIL reset_prom got=%0d exp=0", prom_t); end
    total++; if (max_t !== 8'd0) begin bad++; $display("FAIL reset_max got=%0d exp=0", max_t); end
    total++; if (min_t !== 8'd255) begin bad++; $display("FAIL reset_min got=%0d exp=255", min_t); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
    rst_n = 1'b1; en = 1'b0;
  endtask

  task automatic test_fill();
    en = 1'b1;
    deco = 8'd32; tick();
    deco = 8'd33; tick();
    deco = 8'd34; tick();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL fill_valid3 got=%b exp=0", valid); end
    total++; if (prom_t !== 8'd0) begin bad++; $display("FAIL fill_prom3 got=%0d exp=0", prom_t); end
    deco = 8'd35; tick();
    en = 1'b0;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL fill_valid4 got=%b exp=1", valid); end
    total++; if (prom_t !== 8'd33) begin bad++; $display("FAIL fill_prom got=%0d exp=33", prom_t); end
    total++; if (max_t !== 8'd35) begin bad++; $display("FAIL fill_max got=%0d exp=35", max_t); end
    total++; if (min_t !== 8'd32) begin bad++; $display("FAIL fill_min got=%0d exp=32", min_t); end
    total++; if (reg_t !== 8'd35) begin bad++; $display("FAIL fill_reg got=%0d exp=35", reg_t); end
  endtask

  task automatic test_wrap();
    sample(8'd36);
    total++; if (prom_t !== 8'd34) begin bad++; $display("FAIL wrap_prom got=%0d exp=34", prom_t); end
    sample(8'd0); sample(8'd0); sample(8'd0);
    total++; if (prom_t !== 8'd9) begin bad++; $display("FAIL wrap_prom0 got=%0d exp=9", prom_t); end
    total++; if (min_t !== 8'd0) begin bad++; $display("FAIL wrap_min got=%0d exp=0", min_t); end
    total++; if (max_t !== 8'd36) begin bad++; $display("FAIL wrap_max got=%0d exp=36", max_t); end
  endtask

  task automatic test_hysteresis();
    logic [7:0] exp_up [4];
    logic [7:0] exp_mid [4];
    exp_up = '{8'd11, 8'd22, 8'd33, 8'd44};
    exp_mid = '{8'd42, 8'd41, 8'd39, 8'd38};
    en = 1'b1; deco = 8'd44;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (prom_t !== exp_up[i]) begin bad++; $display("FAIL hyst_up%0d got=%0d exp=%0d", i, prom_t, exp_up[i]); end
    end
    en = 1'b0;
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL hyst_alarm_lat got=%b exp=0", alarm); end
    tick();
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL hyst_alarm_set got=%b exp=1", alarm); end
    en = 1'b1; deco = 8'd38;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (prom_t !== exp_mid[i]) begin bad++; $display("FAIL hyst_mid%0d got=%0d exp=%0d", i, prom_t, exp_mid[i]); end
      total++; if (alarm !== 1'b1) begin bad++; $display("FAIL hyst_hold%0d got=%b exp=1", i, alarm); end
    end
    deco = 8'd34;
    tick(); tick(); tick();
    total++; if (prom_t !== 8'd35) begin bad++; $display("FAIL hyst_prom35 got=%0d exp=35", prom_t); end
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL hyst_alarm35 got=%b exp=1", alarm); end
    tick();
    en = 1'b0;
    total++; if (prom_t !== 8'd34) begin bad++; $display("FAIL hyst_prom34 got=%0d exp=34", prom_t); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL hyst_alarm_clr got=%b exp=0", alarm); end
    tick();
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL hyst_alarm_stay got=%b exp=0", alarm); end
  endtask

  task automatic test_gating();
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      deco = (i % 2 == 0) ? 8'd0 : 8'd255;
      tick();
      total++;
      if (reg_t !== 8'd34 || prom_t !== 8'd34 || max_t !== 8'd44 ||
          min_t !== 8'd0 || valid !== 1'b1 || alarm !== 1'b0) begin
        bad++;
        $display("FAIL gate%0d got reg=%0d prom=%0d max=%0d min=%0d v=%b a=%b exp 34/34/44/0/1/0",
                 i, reg_t, prom_t, max_t, min_t, valid, alarm);
      end
    end
  endtask

  task automatic test_clear();
    clr = 1'b1; en = 1'b1; deco = 8'd50;
    tick();
    clr = 1'b0; en = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", valid); end
    total++; if (prom_t !== 8'd0) begin bad++; $display("FAIL clr_prom got=%0d exp=0", prom_t); end
    total++; if (max_t !== 8'd0) begin bad++; $display("FAIL clr_max got=%0d exp=0", max_t); end
    total++; if (min_t !== 8'd255) begin bad++; $display("FAIL clr_min got=%0d exp=255", min_t); end
    total++; if (reg_t !== 8'd34) begin bad++; $display("FAIL clr_reg got=%0d exp=34", reg_t); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL clr_alarm got=%b exp=0", alarm); end
    sample(8'd10); sample(8'd20); sample(8'd30);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL clr_refill3 got=%b exp=0", valid); end
    sample(8'd40);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL clr_refill4 got=%b exp=1", valid); end
    total++; if (prom_t !== 8'd25) begin bad++; $display("FAIL clr_refill_prom got=%0d exp=25", prom_t); end
    total++; if (max_t !== 8'd40) begin bad++; $display("FAIL clr_refill_max got=%0d exp=40", max_t); end
    total++; if (min_t !== 8'd10) begin bad++; $display("FAIL clr_refill_min got=%0d exp=10", min_t); end
  endtask

  task automatic test_reset_midfill();
    clr = 1'b1; tick(); clr = 1'b0;
    sample(8'd100); sample(8'd100);
    rst_n = 1'b0; en = 1'b1; deco = 8'd200;
    tick();
    rst_n = 1'b1; en = 1'b0;
    total++; if (reg_t !== 8'd0) begin bad++; $display("FAIL rst_mid_reg got=%0d exp=0", reg_t); end
    total++; if (max_t !== 8'd0) begin bad++; $display("FAIL rst_mid_max got=%0d exp=0", max_t); end
    sample(8'd8); sample(8'd12); sample(8'd16);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid3 got=%b exp=0", valid); end
    sample(8'd20);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL rst_mid_valid4 got=%b exp=1", valid); end
    total++; if (prom_t !== 8'd14) begin bad++; $display("FAIL rst_mid_prom got=%0d exp=14", prom_t); end
    total++; if (max_t !== 8'd20) begin bad++; $display("FAIL rst_mid_max2 got=%0d exp=20", max_t); end
    total++; if (min_t !== 8'd8) begin bad++; $display("FAIL rst_mid_min got=%0d exp=8", min_t); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; deco = 8'd0;
    test_reset();
    test_fill();
    test_wrap();
    test_hysteresis();
    test_gating();
    test_clear();
    test_reset_midfill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
